uart_rx_framer: RTL and testbench
=================================

# uart_rx_framer

UART receiver for the SoC's `io_uart_rx` pin. It recovers 8-bit frames (start, 8 data bits LSB-first, optional even parity, 1 stop) from an asynchronous serial line and presents each byte on a valid/ready stream with per-byte parity and framing error flags. It sits between the board pin and the CPU-side UART register block, and is the counterpart of the serial transmitter that drives the line.

## Interface
Parameters:
- `DIV_WIDTH`, default 16: width of the bit-period divisor.

Ports:
- `clk` in 1: system clock.
- `nreset` in 1: reset, asynchronous, active-low.
- `io_rx` in 1: serial line. Asynchronous to `clk`. Idles high.
- `io_divisor` in `DIV_WIDTH`: bit period is `io_divisor+1` clocks. Values below 2 are treated as 2.
- `io_parity_en` in 1: 1 means a parity bit follows the data bits.
- `io_data_valid` out 1: holding register is full.
- `io_data_ready` in 1: consumer accepts the byte.
- `io_data_payload` out 8: received byte.
- `io_data_parity_error` out 1: accompanies the payload. Parity bit != XOR of the data bits (even parity).
- `io_data_frame_error` out 1: accompanies the payload. Stop bit was sampled low.
- `io_overrun` out 1: one-cycle pulse. A completed byte was dropped because the holding register was full.

## Operation
- Synchronizer: two flops, reset value 1. `rx_s` is the output of the second flop.
- The divisor and `io_parity_en` are latched when a start bit is detected. Changes mid-frame have no effect.
- Bit counter counts down to 0. "Expiry" means count == 0, after which the counter reloads the latched divisor.
- States:
  - WAIT_IDLE: stay until `rx_s`==1, then go to IDLE. This is the reset state.
  - IDLE: when `rx_s`==0, load the counter with divisor>>1 and go to START.
  - START: at expiry, if `rx_s`==1 the start was a glitch, so go to IDLE. Otherwise go to DATA with bit index 0.
  - DATA: at each expiry, shift `rx_s` into bit[index]. After the 8th sample, go to PARITY if parity is enabled, else go to STOP.
  - PARITY: at expiry, sample the parity bit p. parity_err = p ^ (^data).
  - STOP: at expiry, sample the stop bit and complete the frame.
    - Stop bit 1: go to IDLE.
    - Stop bit 0: set frame_err and go to WAIT_IDLE.
- Completion is the same for both stop-bit outcomes:
  - If the holding register is free (or is being consumed this cycle), load payload and flags and set valid.
  - Otherwise drop the byte, keep the old contents, and pulse `io_overrun`.
- When parity is disabled, parity_error is always 0.
- Holding register: valid clears on the cycle after `valid && ready`.
  - Simultaneous `valid && ready` and completion: the old byte is consumed, the new byte is loaded, valid stays 1, and no overrun is raised.

## Timing
- Reset values:
  - All outputs 0.
  - Synchronizer flops 1, state WAIT_IDLE.
  - Counter, shift register and index 0.
- Reset mid-frame aborts the frame without delivering it. After release the block requires the line high before it hunts for a new start bit.
- The start bit is detected 2 clocks after the `io_rx` falling edge (synchronizer delay).
- Sample points are mid-bit, D = latched divisor:
  - Start bit is sampled (D>>1)+1 clocks after detection.
  - Each later bit is sampled D+1 clocks after the previous sample.
- `io_data_valid` and the payload rise on the clock after the stop-sample cycle.
- `io_overrun` is high for exactly that one clock.
- Payload and flags are stable while valid=1 and ready=0.
- Back-to-back frames with zero idle bits are received. Start detection in IDLE happens on the cycle after the stop sample.

## Test plan
- `io_divisor`=2 (48 MHz clock, 16 Mbaud), parity enabled, ready=1. Send 0xA5 with parity 0 → payload 0xA5, both error flags 0, valid high for 1 cycle.
- Send 0x01 with the parity bit forced to 0 → payload 0x01, parity_error=1, frame_error=0. The next frame, 0x7E with correct parity, is received with no errors.
- Send 0x3C, then hold the line low for 2 extra bits before returning high → payload 0x3C with frame_error=1. No byte is emitted during the low period. A following 0x55 frame is received error-free.
- Ready=0. Send 0x11 then 0x22 → payload stays 0x11 and `io_overrun` pulses once at the 0x22 stop sample. Then set ready=1 → 0x11 is consumed, valid goes 0 and stays 0.
- `io_divisor`=15. Pulse `io_rx` low for 3 clocks → no output and no flags, and the block is back in IDLE. The next valid frame, 0xC3, is received correctly.
- Parity disabled, divisor 2. Assert `nreset` mid-DATA of a frame and release it while the line is low → no byte is emitted. After the line returns high, a full 0x9A frame yields payload 0x9A.

Source files
------------

// File: rtl/uart_rx_framer.sv
// UART receiver: 8 data bits LSB-first, optional even parity, one stop bit.
// Delivers each byte through a one-deep valid/ready holding register with error flags.
module uart_rx_framer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 io_rx,
    input  logic [DIV_WIDTH-1:0] io_divisor,
    input  logic                 io_parity_en,
    output logic                 io_data_valid,
    input  logic                 io_data_ready,
    output logic [7:0]           io_data_payload,
    output logic                 io_data_parity_error,
    output logic                 io_data_frame_error,
    output logic                 io_overrun
);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic                 rx_m, rx_s;
    logic [1:0]           sync_fill;
    logic [DIV_WIDTH-1:0] div_eff, div_lat, cnt;
    logic                 par_en_lat;
    logic [2:0]           idx;
    logic [7:0]           shreg;
    logic                 perr;
    logic                 expire;
    logic                 start_det, data_smp, par_smp, stop_smp, load;

    // The flops reset high, so their first two outputs after reset are not real
    // line samples; sync_fill marks when the synchronizer holds genuine data.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_m      <= io_rx;
            rx_s      <= rx_m;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign div_eff = (io_divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : io_divisor;
    assign expire  = (cnt == '0);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= WAIT_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_IDLE: if (rx_s && sync_fill[1]) state_nxt = IDLE;
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (expire) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (expire && idx == 3'd7) state_nxt = par_en_lat ? PARITY : STOP;
            PARITY:    if (expire) state_nxt = STOP;
            STOP:      if (expire) state_nxt = rx_s ? IDLE : WAIT_IDLE;
            default:   state_nxt = WAIT_IDLE;
        endcase
    end

    always_comb begin
        start_det = 1'b0;
        data_smp  = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE:    start_det = !rx_s;
            DATA:    data_smp  = expire;
            PARITY:  par_smp   = expire;
            STOP:    stop_smp  = expire;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_lat    <= '0;
            par_en_lat <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            perr       <= 1'b0;
        end else begin
            if (start_det) begin
                div_lat    <= div_eff;
                par_en_lat <= io_parity_en;
                cnt        <= div_eff >> 1;
                idx        <= '0;
                perr       <= 1'b0;
            end else if (state inside {START, DATA, PARITY, STOP}) begin
                cnt <= expire ? div_lat : cnt - 1'b1;
            end
            if (data_smp) begin
                shreg[idx] <= rx_s;
                idx        <= idx + 1'b1;
            end
            if (par_smp) perr <= rx_s ^ (^shreg);
        end
    end

    // A byte being consumed this cycle frees the register for the completing one.
    assign load = stop_smp && (!io_data_valid || io_data_ready);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            io_data_valid        <= 1'b0;
            io_data_payload      <= '0;
            io_data_parity_error <= 1'b0;
            io_data_frame_error  <= 1'b0;
            io_overrun           <= 1'b0;
        end else begin
            io_overrun <= stop_smp && io_data_valid && !io_data_ready;
            if (load) begin
                io_data_valid        <= 1'b1;
                io_data_payload      <= shreg;
                io_data_parity_error <= perr;
                io_data_frame_error  <= !rx_s;
            end else if (io_data_valid && io_data_ready) begin
                io_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: serial frames are driven bit by bit and the
// accepted bytes, valid cycles and overrun pulses are compared to hand-computed values.
module tb_uart_rx_framer;

    logic        clk = 1'b0;
    logic        nreset;
    logic        io_rx;
    logic [15:0] io_divisor;
    logic        io_parity_en;
    logic        io_data_valid;
    logic        io_data_ready;
    logic [7:0]  io_data_payload;
    logic        io_data_parity_error;
    logic        io_data_frame_error;
    logic        io_overrun;

    int n_chk  = 0;
    int n_fail = 0;
    int per    = 3;
    int vcyc   = 0;
    int ocnt   = 0;
    int nq, nv, no;
    logic [9:0] rxq[$];

    uart_rx_framer #(.DIV_WIDTH(16)) dut (
        .clk                  (clk),
        .nreset               (nreset),
        .io_rx                (io_rx),
        .io_divisor           (io_divisor),
        .io_parity_en         (io_parity_en),
        .io_data_valid        (io_data_valid),
        .io_data_ready        (io_data_ready),
        .io_data_payload      (io_data_payload),
        .io_data_parity_error (io_data_parity_error),
        .io_data_frame_error  (io_data_frame_error),
        .io_overrun           (io_overrun)
    );

    always #5 clk = ~clk;

    // Record accepted bytes as {frame_error, parity_error, payload}.
    always @(negedge clk) begin
        if (nreset) begin
            if (io_data_valid) vcyc++;
            if (io_overrun) ocnt++;
            if (io_data_valid && io_data_ready)
                rxq.push_back({io_data_frame_error, io_data_parity_error, io_data_payload});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_byte(input string tag, input int i, input logic [9:0] exp_v);
        chk(tag, (i < rxq.size()) ? {22'd0, rxq[i]} : 32'hDEAD_BEEF, {22'd0, exp_v});
    endtask

    // Leaves the line at the stop-bit level when it returns.
    task automatic frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
        io_rx = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            io_rx = d[i];
            tick(per);
        end
        if (pen) begin
            io_rx = pbit;
            tick(per);
        end
        io_rx = stop;
        tick(per);
    endtask

    initial begin
        nreset        = 1'b0;
        io_rx         = 1'b1;
        io_divisor    = 16'd2;
        io_parity_en  = 1'b1;
        io_data_ready = 1'b1;
        tick(3);
        chk("rst_valid",   io_data_valid, 0);
        chk("rst_payload", io_data_payload, 0);
        chk("rst_perr",    io_data_parity_error, 0);
        chk("rst_ferr",    io_data_frame_error, 0);
        chk("rst_overrun", io_overrun, 0);
        nreset = 1'b1;
        tick(8);

        // 0xA5, correct even parity 0
        frame(8'hA5, 1'b1, 1'b0, 1'b1);
        tick(6);
        chk("a5_count", rxq.size(), 1);
        chk_byte("a5_byte", 0, {2'b00, 8'hA5});
        chk("a5_vcyc", vcyc, 1);

        // 0x01 with bad parity, then 0x7E back to back
        frame(8'h01, 1'b1, 1'b0, 1'b1);
        frame(8'h7E, 1'b1, 1'b0, 1'b1);
        tick(6);
        chk("perr_count", rxq.size(), 3);
        chk_byte("perr_byte", 1, {2'b01, 8'h01});
        chk_byte("7e_byte", 2, {2'b00, 8'h7E});

        // 0x3C with stop bit low and the line held low two more bits
        frame(8'h3C, 1'b1, 1'b0, 1'b0);
        tick(2 * per);
        chk("ferr_count", rxq.size(), 4);
        chk_byte("ferr_byte", 3, {2'b10, 8'h3C});
        io_rx = 1'b1;
        tick(3 * per);
        chk("ferr_quiet", rxq.size(), 4);
        frame(8'h55, 1'b1, 1'b0, 1'b1);
        tick(6);
        chk("55_count", rxq.size(), 5);
        chk_byte("55_byte", 4, {2'b00, 8'h55});

        // Overrun: consumer stalled across two frames
        io_data_ready = 1'b0;
        nq = rxq.size();
        frame(8'h11, 1'b1, 1'b0, 1'b1);
        tick(4);
        chk("ovr_none_yet", ocnt, 0);
        frame(8'h22, 1'b1, 1'b0, 1'b1);
        tick(6);
        chk("ovr_pulses",  ocnt, 1);
        chk("ovr_valid",   io_data_valid, 1);
        chk("ovr_payload", io_data_payload, 8'h11);
        chk("ovr_perr",    io_data_parity_error, 0);
        chk("ovr_ferr",    io_data_frame_error, 0);
        chk("ovr_noacc",   rxq.size(), nq);
        io_data_ready = 1'b1;
        tick(4);
        chk("ovr_drain_valid", io_data_valid, 0);
        chk("ovr_drain_count", rxq.size(), nq + 1);
        chk_byte("ovr_drain_byte", nq, {2'b00, 8'h11});
        tick(10);
        chk("ovr_stays_low", io_data_valid, 0);

        // Short glitch with a long divisor
        io_divisor = 16'd15;
        per = 16;
        tick(4);
        nq = rxq.size();
        nv = vcyc;
        no = ocnt;
        io_rx = 1'b0;
        tick(3);
        io_rx = 1'b1;
        tick(40);
        chk("glitch_count",   rxq.size(), nq);
        chk("glitch_vcyc",    vcyc, nv);
        chk("glitch_overrun", ocnt, no);
        frame(8'hC3, 1'b1, 1'b0, 1'b1);
        tick(6);
        chk("c3_count", rxq.size(), nq + 1);
        chk_byte("c3_byte", nq, {2'b00, 8'hC3});

        // Reset mid-DATA, released while the line is still low
        io_parity_en = 1'b0;
        io_divisor   = 16'd2;
        per = 3;
        tick(4);
        nq = rxq.size();
        nv = vcyc;
        no = ocnt;
        io_rx = 1'b0;
        tick(per);
        io_rx = 1'b0;
        tick(per);
        io_rx = 1'b1;
        tick(per);
        io_rx = 1'b0;
        tick(1);
        nreset = 1'b0;
        tick(1);
        chk("midrst_valid", io_data_valid, 0);
        nreset = 1'b1;
        tick(20);
        io_rx = 1'b1;
        tick(10);
        chk("midrst_count",   rxq.size(), nq);
        chk("midrst_vcyc",    vcyc, nv);
        chk("midrst_overrun", ocnt, no);
        frame(8'h9A, 1'b0, 1'b0, 1'b1);
        tick(6);
        chk("9a_count", rxq.size(), nq + 1);
        chk_byte("9a_byte", nq, {2'b00, 8'h9A});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
